lcd_8080_receiver: RTL and testbench

- Panel-side responder for the 8-bit 8080-style LCD bus (lcd_db, lcd_wr, lcd_d_c, lcd_rd, lcd_reset) that the screen controller drives towards the Arduino-header display.
- Decodes the window and memory-write commands and emits one pixel write (x, y, RGB565) per two data bytes.
- Used as an on-chip loopback and checker of the LCD path, and as the bus model in benches.
- Runs on clk_100 and treats all bus pins as asynchronous.

---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_bus_sync.sv | 52 +++++
 rtl/lcd_8080_receiver.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_8080_receiver.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the 8080-style LCD bus receiver.
//   - Command codes recognised by the receiver.
//   - Receiver state encoding (RAMWRC reuses the RAMWR state).
//   - RGB565 packing / field slice helpers.
package lcd_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

  typedef enum logic [2:0] {
    IDLE,
    CASET,
    PASET,
    RAMWR,
    SKIP
  } lcd_rx_state_t;

  // First bus byte carries the upper half of the RGB565 word.
  function automatic logic [15:0] rgb565_pack(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

  function automatic logic [4:0] rgb565_r(input logic [15:0] p);
    return p[15:11];
  endfunction

  function automatic logic [5:0] rgb565_g(input logic [15:0] p);
    return p[10:5];
  endfunction

  function automatic logic [4:0] rgb565_b(input logic [15:0] p);
    return p[4:0];
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Synchronizer for the asynchronous LCD bus pins plus write-strobe edge detect.
// Ports:
//   clk, resetN          sampling clock, async active-low reset
//   db_i, wr_i, d_c_i,   raw bus pins
//   rd_i, rst_i
//   db_s, d_c_s          data byte and D/C from the final synchronizer stage
//   rd_s, rst_s          synchronized read strobe and panel reset (active low)
//   wr_evt               one-cycle pulse on a synchronized wr rising edge
module lcd_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] db_i,
  input  logic       wr_i,
  input  logic       d_c_i,
  input  logic       rd_i,
  input  logic       rst_i,
  output logic [7:0] db_s,
  output logic       d_c_s,
  output logic       rd_s,
  output logic       rst_s,
  output logic       wr_evt
);

  localparam int W = 12;
  // Idle bus levels {rst, rd, d_c, wr, db}: strobes and panel reset high, so
  // leaving reset never fakes a write edge, a read or a soft reset.
  localparam logic [W-1:0] REST_LVL = {1'b1, 1'b1, 1'b0, 1'b1, 8'h00};

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic         wr_prev_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= REST_LVL;
      wr_prev_q <= 1'b1;
    end else begin
      sync_q[0] <= {rst_i, rd_i, d_c_i, wr_i, db_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      wr_prev_q <= sync_q[SYNC_STAGES-1][8];
    end
  end

  // All fields leave the same stage, so db/d_c line up with the wr edge.
  assign db_s   = sync_q[SYNC_STAGES-1][7:0];
  assign d_c_s  = sync_q[SYNC_STAGES-1][9];
  assign rd_s   = sync_q[SYNC_STAGES-1][10];
  assign rst_s  = sync_q[SYNC_STAGES-1][11];
  assign wr_evt = sync_q[SYNC_STAGES-1][8] & ~wr_prev_q;

endmodule

// File: rtl/lcd_8080_receiver.sv
// Panel-side responder for the 8-bit 8080 LCD bus. Decodes CASET/PASET window
// commands and RAMWR/RAMWRC pixel streams, emitting one pixel per two bytes.
// Ports:
//   clk, resetN                  100 MHz clock, async active-low reset
//   lcd_db/wr/d_c/rd/reset       asynchronous bus pins
//   pix_valid, pix_x/y, pix_rgb  pixel write pulse with position and colour
//   cmd_valid, cmd_code          pulse per command byte, last command
//   frame_done                   pulse with the pixel that wraps past (xe,ye)
//   bus_err                      sticky: read strobe seen
module lcd_8080_receiver
  import lcd_pkg::*;
#(
  parameter int PANEL_W     = 320,
  parameter int PANEL_H     = 240,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic [7:0]                 lcd_db,
  input  logic                       lcd_wr,
  input  logic                       lcd_d_c,
  input  logic                       lcd_rd,
  input  logic                       lcd_reset,
  output logic                       pix_valid,
  output logic [$clog2(PANEL_W)-1:0] pix_x,
  output logic [$clog2(PANEL_H)-1:0] pix_y,
  output logic [15:0]                pix_rgb,
  output logic                       cmd_valid,
  output logic [7:0]                 cmd_code,
  output logic                       frame_done,
  output logic                       bus_err
);

  localparam int XW = $clog2(PANEL_W);
  localparam int YW = $clog2(PANEL_H);
  localparam logic [XW-1:0] X_MAX = XW'(PANEL_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(PANEL_H - 1);

  logic [7:0] db_s;
  logic       d_c_s, rd_s, rst_s, wr_evt;

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .resetN(resetN),
    .db_i  (lcd_db),
    .wr_i  (lcd_wr),
    .d_c_i (lcd_d_c),
    .rd_i  (lcd_rd),
    .rst_i (lcd_reset),
    .db_s  (db_s),
    .d_c_s (d_c_s),
    .rd_s  (rd_s),
    .rst_s (rst_s),
    .wr_evt(wr_evt)
  );

  function automatic logic [XW-1:0] clip_x(input logic [15:0] v);
    if (v > 16'(PANEL_W - 1)) return X_MAX;
    return v[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] clip_y(input logic [15:0] v);
    if (v > 16'(PANEL_H - 1)) return Y_MAX;
    return v[YW-1:0];
  endfunction

  lcd_rx_state_t state_q, state_d;
  logic [XW-1:0] xs_q, xs_d, xe_q, xe_d, x_q, x_d, pix_x_q, pix_x_d;
  logic [YW-1:0] ys_q, ys_d, ye_q, ye_d, y_q, y_d, pix_y_q, pix_y_d;
  logic [23:0]   par_q, par_d;   // first three params: SC_hi, SC_lo, EC_hi
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    hi_q, hi_d, cmd_code_q, cmd_code_d;
  logic          half_q, half_d;
  logic [15:0]   pix_rgb_q, pix_rgb_d;
  logic          pix_valid_q, pix_valid_d, cmd_valid_q, cmd_valid_d;
  logic          frame_done_q, frame_done_d, bus_err_q, bus_err_d;
  logic [15:0]   sc, ec;
  logic [XW-1:0] cx_lo, cx_hi;
  logic [YW-1:0] cy_lo, cy_hi;

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!rst_s) begin
      state_d = IDLE;
    end else if (wr_evt) begin
      if (!d_c_s) begin
        case (db_s)
          CMD_CASET:              state_d = CASET;
          CMD_PASET:              state_d = PASET;
          CMD_RAMWR, CMD_RAMWRC:  state_d = RAMWR;
          CMD_SWRESET:            state_d = IDLE;
          default:                state_d = SKIP;
        endcase
      end else if ((state_q == CASET || state_q == PASET) && cnt_q == 3'd3) begin
        state_d = SKIP;
      end
    end
  end

  assign sc    = par_q[23:8];
  assign ec    = {par_q[7:0], db_s};
  assign cx_lo = clip_x(sc);
  assign cx_hi = clip_x(ec);
  assign cy_lo = clip_y(sc);
  assign cy_hi = clip_y(ec);

  // Datapath and output logic
  always_comb begin
    xs_d = xs_q; xe_d = xe_q; ys_d = ys_q; ye_d = ye_q;
    x_d = x_q; y_d = y_q; par_d = par_q; cnt_d = cnt_q;
    hi_d = hi_q; half_d = half_q;
    pix_x_d = pix_x_q; pix_y_d = pix_y_q; pix_rgb_d = pix_rgb_q;
    cmd_code_d = cmd_code_q;
    pix_valid_d = 1'b0; cmd_valid_d = 1'b0; frame_done_d = 1'b0;
    bus_err_d = bus_err_q | ~rd_s;

    if (!rst_s) begin
      // Soft reset wins over a simultaneous write; only bus_err survives.
      xs_d = '0; xe_d = X_MAX; ys_d = '0; ye_d = Y_MAX;
      x_d = '0; y_d = '0; par_d = '0; cnt_d = '0; hi_d = '0; half_d = 1'b0;
      pix_x_d = '0; pix_y_d = '0; pix_rgb_d = '0; cmd_code_d = '0;
    end else if (wr_evt) begin
      if (!d_c_s) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = db_s;
        half_d      = 1'b0;
        cnt_d       = '0;
        if (db_s == CMD_RAMWR) begin
          x_d = xs_q;
          y_d = ys_q;
        end else if (db_s == CMD_SWRESET) begin
          xs_d = '0; xe_d = X_MAX; ys_d = '0; ye_d = Y_MAX;
          x_d = '0; y_d = '0;
        end
      end else begin
        case (state_q)
          CASET, PASET: begin
            if (cnt_q != 3'd4) cnt_d = cnt_q + 3'd1;
            case (cnt_q)
              3'd0: par_d[23:16] = db_s;
              3'd1: par_d[15:8]  = db_s;
              3'd2: par_d[7:0]   = db_s;
              3'd3: begin
                if (state_q == CASET) begin
                  xs_d = cx_lo;
                  xe_d = (cx_lo > cx_hi) ? cx_lo : cx_hi;
                end else begin
                  ys_d = cy_lo;
                  ye_d = (cy_lo > cy_hi) ? cy_lo : cy_hi;
                end
              end
              default: ;
            endcase
          end
          RAMWR: begin
            if (!half_q) begin
              hi_d   = db_s;
              half_d = 1'b1;
            end else begin
              half_d      = 1'b0;
              pix_valid_d = 1'b1;
              pix_rgb_d   = rgb565_pack(hi_q, db_s);
              pix_x_d     = x_q;
              pix_y_d     = y_q;
              if (x_q == xe_q) begin
                x_d = xs_q;
                if (y_q == ye_q) begin
                  y_d          = ys_q;
                  frame_done_d = 1'b1;
                end else begin
                  y_d = y_q + YW'(1);
                end
              end else begin
                x_d = x_q + XW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      xs_q <= '0; xe_q <= X_MAX; ys_q <= '0; ye_q <= Y_MAX;
      x_q <= '0; y_q <= '0; par_q <= '0; cnt_q <= '0;
      hi_q <= '0; half_q <= 1'b0;
      pix_x_q <= '0; pix_y_q <= '0; pix_rgb_q <= '0; cmd_code_q <= '0;
      pix_valid_q <= 1'b0; cmd_valid_q <= 1'b0; frame_done_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      xs_q <= xs_d; xe_q <= xe_d; ys_q <= ys_d; ye_q <= ye_d;
      x_q <= x_d; y_q <= y_d; par_q <= par_d; cnt_q <= cnt_d;
      hi_q <= hi_d; half_q <= half_d;
      pix_x_q <= pix_x_d; pix_y_q <= pix_y_d; pix_rgb_q <= pix_rgb_d;
      cmd_code_q <= cmd_code_d;
      pix_valid_q <= pix_valid_d; cmd_valid_q <= cmd_valid_d;
      frame_done_q <= frame_done_d; bus_err_q <= bus_err_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_rgb    = pix_rgb_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign frame_done = frame_done_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_lcd_8080_receiver.sv
// Scoreboard bench for lcd_8080_receiver: expected pixels and commands are
// queued as the bus is driven and popped when the DUT pulses its outputs.
module tb_lcd_8080_receiver;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] lcd_db = 8'h00;
  logic       lcd_wr = 1'b1;
  logic       lcd_d_c = 1'b0;
  logic       lcd_rd = 1'b1;
  logic       lcd_reset = 1'b1;
  logic       pix_valid, cmd_valid, frame_done, bus_err;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic [15:0] pix_rgb;
  logic [7:0] cmd_code;

  lcd_8080_receiver #(.PANEL_W(320), .PANEL_H(240), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .lcd_db    (lcd_db),
    .lcd_wr    (lcd_wr),
    .lcd_d_c   (lcd_d_c),
    .lcd_rd    (lcd_rd),
    .lcd_reset (lcd_reset),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_rgb   (pix_rgb),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .frame_done(frame_done),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [15:0] rgb;
    logic        fd;
  } pix_t;

  pix_t       exp_pix[$];
  logic [7:0] exp_cmd[$];
  pix_t       mon_p;
  logic [7:0] mon_c;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (pix_valid) begin
      if (exp_pix.size() == 0) begin
        check("pix_unexpected", 32'd1, 32'd0);
      end else begin
        mon_p = exp_pix.pop_front();
        check("pix_x", 32'(pix_x), 32'(mon_p.x));
        check("pix_y", 32'(pix_y), 32'(mon_p.y));
        check("pix_rgb", 32'(pix_rgb), 32'(mon_p.rgb));
        check("frame_done", 32'(frame_done), 32'(mon_p.fd));
      end
    end else if (frame_done) begin
      check("frame_done_stray", 32'd1, 32'd0);
    end
    if (cmd_valid) begin
      if (exp_cmd.size() == 0) begin
        check("cmd_unexpected", 32'd1, 32'd0);
      end else begin
        mon_c = exp_cmd.pop_front();
        check("cmd_code", 32'(cmd_code), 32'(mon_c));
      end
    end
  end

  task automatic bus_wr(input logic dc, input logic [7:0] b);
    @(posedge clk); #2;
    lcd_d_c = dc;
    lcd_db  = b;
    lcd_wr  = 1'b0;
    repeat (3) @(posedge clk); #2;
    lcd_wr = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    exp_cmd.push_back(c);
    bus_wr(1'b0, c);
  endtask

  task automatic send_par(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    bus_wr(1'b1, a); bus_wr(1'b1, b); bus_wr(1'b1, c); bus_wr(1'b1, d);
  endtask

  task automatic send_pix(input logic [7:0] hi, input logic [7:0] lo,
                          input int ex, input int ey, input logic efd);
    pix_t p;
    p.x = 9'(ex); p.y = 8'(ey); p.rgb = {hi, lo}; p.fd = efd;
    exp_pix.push_back(p);
    bus_wr(1'b1, hi);
    bus_wr(1'b1, lo);
  endtask

  task automatic check_outputs_zero(input string tag, input logic err_exp);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    check({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    check({tag, "_pix_rgb"}, 32'(pix_rgb), 32'd0);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_cmd_code"}, 32'(cmd_code), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'(err_exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk); #1;
    check_outputs_zero("reset", 1'b0);
    #2 resetN = 1'b1;
    repeat (4) @(posedge clk);

    // Single pixel at origin with the full-screen window
    send_cmd(8'h2C);
    send_pix(8'hF8, 8'h00, 0, 0, 1'b0);

    // 3x2 window with wrap and frame_done
    send_cmd(8'h2A); send_par(8'h00, 8'd10, 8'h00, 8'd12);
    send_cmd(8'h2B); send_par(8'h00, 8'd5, 8'h00, 8'd6);
    send_cmd(8'h2C);
    send_pix(8'h10, 8'h01, 10, 5, 1'b0);
    send_pix(8'h10, 8'h02, 11, 5, 1'b0);
    send_pix(8'h10, 8'h03, 12, 5, 1'b0);
    send_pix(8'h10, 8'h04, 10, 6, 1'b0);
    send_pix(8'h10, 8'h05, 11, 6, 1'b0);
    send_pix(8'h10, 8'h06, 12, 6, 1'b1);
    send_pix(8'h10, 8'h07, 10, 5, 1'b0);

    // Half pixel dropped by RAMWRC; pointer continues from (11,5)
    bus_wr(1'b1, 8'hAB);
    send_cmd(8'h3C);
    send_pix(8'h12, 8'h34, 11, 5, 1'b0);

    // Columns beyond the panel clip to 319, xs=xe
    send_cmd(8'h2A); send_par(8'h01, 8'h90, 8'h02, 8'h00);
    send_cmd(8'h2C);
    send_pix(8'h5A, 8'h01, 319, 5, 1'b0);
    send_pix(8'h5A, 8'h02, 319, 6, 1'b1);
    send_pix(8'h5A, 8'h03, 319, 5, 1'b0);

    // Read strobe while wr low: bus_err set, no pixel
    check("bus_err_before_rd", 32'(bus_err), 32'd0);
    send_cmd(8'h00);
    @(posedge clk); #2;
    lcd_d_c = 1'b1; lcd_db = 8'hEE; lcd_wr = 1'b0;
    repeat (2) @(posedge clk); #2 lcd_rd = 1'b0;
    repeat (4) @(posedge clk); #2 lcd_rd = 1'b1;
    repeat (2) @(posedge clk); #2 lcd_wr = 1'b1;
    repeat (8) @(posedge clk);
    check("bus_err_after_rd", 32'(bus_err), 32'd1);
    repeat (10) @(posedge clk);
    check("bus_err_sticky", 32'(bus_err), 32'd1);

    // Panel soft reset mid-stream: outputs cleared, bus_err kept
    send_cmd(8'h2C);
    bus_wr(1'b1, 8'h55);
    @(posedge clk); #2 lcd_reset = 1'b0;
    repeat (4) @(posedge clk); #2 lcd_reset = 1'b1;
    repeat (6) @(posedge clk); #1;
    check_outputs_zero("soft_reset", 1'b1);
    send_cmd(8'h2C);
    send_pix(8'hAA, 8'hBB, 0, 0, 1'b0);
    send_pix(8'hCC, 8'hDD, 1, 0, 1'b0);

    // resetN asserted while a byte strobe is low
    @(posedge clk); #2;
    lcd_d_c = 1'b1; lcd_db = 8'h77; lcd_wr = 1'b0;
    repeat (2) @(posedge clk); #2 resetN = 1'b0;
    #1;
    check_outputs_zero("async_reset", 1'b0);
    repeat (2) @(posedge clk); #2 lcd_wr = 1'b1;
    repeat (3) @(posedge clk); #2 resetN = 1'b1;
    repeat (6) @(posedge clk);
    send_cmd(8'h2C);
    send_pix(8'h07, 8'hE0, 0, 0, 1'b0);

    repeat (10) @(posedge clk);
    check("pix_queue_drained", 32'(exp_pix.size()), 32'd0);
    check("cmd_queue_drained", 32'(exp_cmd.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
